// File: rtl/clk_div_pkg.sv
// Shared definitions for the divisor-change controller.
//   state_e : controller FSM encoding (IDLE, PENDING)
//   DIV_MIN : smallest divisor that is ever put into effect
package clk_div_pkg;
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    localparam int DIV_MIN = 2;
endpackage

// File: rtl/clk_div_ctrl_rr_arbiter.sv
// Round-robin arbiter for divisor-change requesters.
//   clk_in  : clock (rising edge)
//   rst_n   : asynchronous active-low reset, pointer returns to requester 0
//   req     : request vector
//   advance : move the pointer past the currently granted requester
//   gnt     : one-hot grant (combinational), zero when no request is present
module rr_arbiter
    import clk_div_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] gnt
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] ptr_nxt_s;

    // Pick the first requesting index at or after the pointer, wrapping around.
    always_comb begin : pick
        int  idx;
        logic found;
        gnt       = '0;
        ptr_nxt_s = ptr_r;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_r) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end else begin
                idx = idx;
            end
            if (!found && req[idx]) begin
                gnt[idx]  = 1'b1;
                found     = 1'b1;
                ptr_nxt_s = (idx == N_REQ - 1) ? '0 : PTR_W'(idx + 1);
            end else begin
                found = found;
            end
        end
    end

    // Pointer register, updated only when a grant is actually taken.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (advance) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with arbitrated, glitch-free divisor changes.
//   clk_in  : single clock, rising edge
//   rst_n   : asynchronous active-low reset
//   en      : divider run enable (low parks the counter at 0)
//   req     : per-requester divisor-change request, held until granted
//   req_div : requested divisors, requester i in [i*DIV_W +: DIV_W]
//   grant   : one-hot one-cycle acceptance pulse
//   busy    : a captured change is waiting for its period boundary
//   applied : one-cycle pulse in the first cycle of a new divisor
//   cur_div : divisor in effect
//   clk_out : divided clock, low for floor(div/2) cycles then high
//   tick    : strobe in the last cycle of each period
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 12
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DIV_W-1:0] req_div,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic                   applied,
    output logic [DIV_W-1:0]       cur_div,
    output logic                   clk_out,
    output logic                   tick
);
    state_e             state_r, state_nxt_s;
    logic [DIV_W-1:0]   cnt_r, cnt_nxt_s;
    logic [DIV_W-1:0]   cur_div_r, cur_div_nxt_s;
    logic [DIV_W-1:0]   pend_div_r, pend_div_nxt_s;
    logic [DIV_W-1:0]   sel_div_s;
    logic [N_REQ-1:0]   gnt_s;
    logic [N_REQ-1:0]   grant_r;
    logic               advance_s, apply_s;
    logic               busy_r, applied_r, clk_out_r, tick_r;
    logic               clk_out_nxt_s, tick_nxt_s;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        if (d < DIV_W'(DIV_MIN)) begin
            return DIV_W'(DIV_MIN);
        end else begin
            return d;
        end
    endfunction

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .req     (req),
        .advance (advance_s),
        .gnt     (gnt_s)
    );

    // Divisor of the granted requester (grant is one-hot, so OR-merge is exact).
    always_comb begin
        sel_div_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_div_s = sel_div_s | (req_div[i*DIV_W +: DIV_W] & {DIV_W{gnt_s[i]}});
        end
    end

    // FSM next state: capture in IDLE, apply at period end (or at once when stopped).
    always_comb begin
        state_nxt_s    = state_r;
        pend_div_nxt_s = pend_div_r;
        advance_s      = 1'b0;
        apply_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    advance_s      = 1'b1;
                    pend_div_nxt_s = clamp_div(sel_div_s);
                    state_nxt_s    = PENDING;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PENDING: begin
                if (!en || (cnt_r >= cur_div_r - DIV_W'(1))) begin
                    apply_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = PENDING;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Counter and output decode; outputs are computed from next-cycle count so
    // the registered clk_out/tick line up with the count they describe.
    always_comb begin
        cur_div_nxt_s = apply_s ? pend_div_r : cur_div_r;
        if (!en) begin
            cnt_nxt_s = '0;
        end else if (cnt_r >= cur_div_r - DIV_W'(1)) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + DIV_W'(1);
        end
        clk_out_nxt_s = en && (cnt_nxt_s >= (cur_div_nxt_s >> 1));
        tick_nxt_s    = en && (cnt_nxt_s == cur_div_nxt_s - DIV_W'(1));
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            cur_div_r  <= DIV_W'(DEFAULT_DIV);
            pend_div_r <= '0;
            grant_r    <= '0;
            busy_r     <= 1'b0;
            applied_r  <= 1'b0;
            clk_out_r  <= 1'b0;
            tick_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            cur_div_r  <= cur_div_nxt_s;
            pend_div_r <= pend_div_nxt_s;
            grant_r    <= gnt_s & {N_REQ{advance_s}};
            busy_r     <= (state_nxt_s == PENDING);
            applied_r  <= apply_s;
            clk_out_r  <= clk_out_nxt_s;
            tick_r     <= tick_nxt_s;
        end
    end

    assign grant   = grant_r;
    assign busy    = busy_r;
    assign applied = applied_r;
    assign cur_div = cur_div_r;
    assign clk_out = clk_out_r;
    assign tick    = tick_r;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl (20 ns clock).
module tb_clk_div_ctrl;
    logic        clk_in;
    logic        rst_n;
    logic        en_s;
    logic [1:0]  req_s;
    logic [15:0] req_div_s;
    logic [1:0]  grant_s;
    logic        busy_s, applied_s, clk_out_s, tick_s;
    logic [7:0]  cur_div_s;

    int checks;
    int errors;

    clk_div_ctrl #(.N_REQ(2), .DIV_W(8), .DEFAULT_DIV(12)) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en_s),
        .req     (req_s),
        .req_div (req_div_s),
        .grant   (grant_s),
        .busy    (busy_s),
        .applied (applied_s),
        .cur_div (cur_div_s),
        .clk_out (clk_out_s),
        .tick    (tick_s)
    );

    initial clk_in = 1'b0;
    // 20 ns clock.
    always #10 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Walk counts [from, to) of a period of length d, checking each cycle.
    task automatic run_cnt(input int d, input int from, input int to);
        for (int k = from; k < to; k++) begin
            chk($sformatf("clk_out d%0d k%0d", d, k), 32'(clk_out_s), 32'(k >= d / 2));
            chk($sformatf("tick d%0d k%0d", d, k), 32'(tick_s), 32'(k == d - 1));
            step();
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " clk_out"}, 32'(clk_out_s), 32'd0);
        chk({tag, " tick"},    32'(tick_s),    32'd0);
        chk({tag, " grant"},   32'(grant_s),   32'd0);
        chk({tag, " busy"},    32'(busy_s),    32'd0);
        chk({tag, " applied"}, 32'(applied_s), 32'd0);
        chk({tag, " cur_div"}, 32'(cur_div_s), 32'd12);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        en_s      = 1'b0;
        req_s     = 2'b00;
        req_div_s = 16'h0000;
        #25;
        chk_reset("reset");
        rst_n = 1'b1;
        en_s  = 1'b1;

        // Default divisor 12: two full periods.
        run_cnt(12, 0, 12);
        run_cnt(12, 0, 12);
        chk("default cur_div", 32'(cur_div_s), 32'd12);

        // Request divisor 4 at cnt=3; applies after the 12-cycle period ends.
        run_cnt(12, 0, 3);
        req_s     = 2'b01;
        req_div_s = {8'd0, 8'd4};
        step();
        chk("div4 grant", 32'(grant_s), 32'd1);
        chk("div4 busy",  32'(busy_s),  32'd1);
        req_s = 2'b00;
        run_cnt(12, 4, 5);
        chk("div4 grant once", 32'(grant_s), 32'd0);
        chk("div4 busy held",  32'(busy_s),  32'd1);
        run_cnt(12, 5, 12);
        chk("div4 applied", 32'(applied_s), 32'd1);
        chk("div4 cur_div", 32'(cur_div_s), 32'd4);
        chk("div4 busy clr", 32'(busy_s), 32'd0);
        run_cnt(4, 0, 4);
        run_cnt(4, 0, 4);
        chk("div4 applied once", 32'(applied_s), 32'd0);

        // Reset pulse so arbitration starts from requester 0.
        rst_n = 1'b0;
        #2;
        chk_reset("mid reset");
        rst_n = 1'b1;
        #2;

        // Both request; requester 0 keeps re-requesting, requester 1 still wins next.
        req_s     = 2'b11;
        req_div_s = {8'd8, 8'd6};
        step();
        chk("rr first grant", 32'(grant_s), 32'd1);
        run_cnt(12, 1, 12);
        chk("rr apply6 cur_div", 32'(cur_div_s), 32'd6);
        chk("rr apply6 applied", 32'(applied_s), 32'd1);
        chk("rr apply6 grant",   32'(grant_s),   32'd0);
        step();
        chk("rr second grant", 32'(grant_s), 32'd2);
        req_s = 2'b00;
        run_cnt(6, 1, 6);
        chk("rr apply8 cur_div", 32'(cur_div_s), 32'd8);
        chk("rr apply8 applied", 32'(applied_s), 32'd1);
        run_cnt(8, 0, 8);

        // Divisor 0 then 1: both clamp to 2.
        req_s     = 2'b01;
        req_div_s = {8'd0, 8'd0};
        step();
        chk("clamp0 grant", 32'(grant_s), 32'd1);
        req_s = 2'b00;
        run_cnt(8, 1, 8);
        chk("clamp0 cur_div", 32'(cur_div_s), 32'd2);
        run_cnt(2, 0, 2);
        run_cnt(2, 0, 2);
        req_s     = 2'b01;
        req_div_s = {8'd0, 8'd1};
        step();
        chk("clamp1 grant", 32'(grant_s), 32'd1);
        req_s = 2'b00;
        run_cnt(2, 1, 2);
        chk("clamp1 cur_div", 32'(cur_div_s), 32'd2);
        chk("clamp1 applied", 32'(applied_s), 32'd1);
        run_cnt(2, 0, 2);

        // en=0 while pending: change applies next cycle, outputs held low.
        req_s     = 2'b01;
        req_div_s = {8'd0, 8'd7};
        step();
        chk("en0 grant", 32'(grant_s), 32'd1);
        req_s = 2'b00;
        en_s  = 1'b0;
        step();
        chk("en0 cur_div", 32'(cur_div_s), 32'd7);
        chk("en0 applied", 32'(applied_s), 32'd1);
        chk("en0 clk_out", 32'(clk_out_s), 32'd0);
        chk("en0 tick",    32'(tick_s),    32'd0);
        chk("en0 busy",    32'(busy_s),    32'd0);
        step();
        chk("en0 hold clk_out", 32'(clk_out_s), 32'd0);
        chk("en0 hold tick",    32'(tick_s),    32'd0);
        chk("en0 hold applied", 32'(applied_s), 32'd0);
        en_s = 1'b1;
        run_cnt(7, 0, 7);

        // Capture on a boundary cycle waits for the following boundary.
        run_cnt(7, 0, 6);
        req_s     = 2'b10;
        req_div_s = {8'd5, 8'd0};
        step();
        chk("bnd grant",   32'(grant_s),   32'd2);
        chk("bnd cur_div", 32'(cur_div_s), 32'd7);
        chk("bnd applied", 32'(applied_s), 32'd0);
        req_s = 2'b00;
        run_cnt(7, 0, 7);
        chk("bnd late cur_div", 32'(cur_div_s), 32'd5);
        chk("bnd late applied", 32'(applied_s), 32'd1);

        // Reset while pending drops the change.
        req_s     = 2'b01;
        req_div_s = {8'd0, 8'd9};
        step();
        chk("rstp grant", 32'(grant_s), 32'd1);
        chk("rstp busy",  32'(busy_s),  32'd1);
        req_s = 2'b00;
        #3;
        rst_n = 1'b0;
        #2;
        chk_reset("rstp");
        rst_n = 1'b1;
        run_cnt(12, 0, 12);
        chk("rstp no applied", 32'(applied_s), 32'd0);
        chk("rstp busy clr",   32'(busy_s),    32'd0);
        chk("rstp cur_div",    32'(cur_div_s), 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- N_REQ, 2, number of divisor-change requesters.
- DIV_W, 8, divisor width in bits.
- DEFAULT_DIV, 12, divisor loaded at reset.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk_in, in, 1, the single clock; all logic is on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, divider run enable.
- req, in, N_REQ, per-requester divisor-change request; held until granted.
- req_div, in, N_REQ*DIV_W, requested divisors; requester i uses slice [i*DIV_W +: DIV_W].
- grant, out, N_REQ, one-hot one-cycle acceptance pulse.
- busy, out, 1, a captured change is pending.
- applied, out, 1, one-cycle pulse in the first cycle a new divisor is in effect.
- cur_div, out, DIV_W, divisor currently in effect.
- clk_out, out, 1, divided clock.
- tick, out, 1, one-cycle period-end strobe.

Function
REQ-003 An internal counter cnt SHALL run 0..cur_div-1 and wrap to 0, advancing by one each cycle while en=1.
REQ-004 clk_out SHALL be 0 for cnt in [0, floor(cur_div/2)-1] and 1 for the rest of the period (div=12: 6 low, 6 high; div=5: 2 low, 3 high).
REQ-005 tick SHALL be 1 exactly in cycles where cnt==cur_div-1 and en=1.
REQ-006 clk_out and tick SHALL be registered, with values that correspond to the cnt value of the same cycle; zero combinational paths from inputs to outputs.
REQ-007 The FSM SHALL have states IDLE and PENDING.
REQ-008 IDLE: if any req bit is set, a round-robin arbiter SHALL select one requester, latch its divisor into pend_div, pulse its grant bit for one cycle, and go to PENDING.
REQ-009 The round-robin pointer SHALL start at requester 0 and move to the requester after the one granted.
REQ-010 PENDING: busy=1; the block SHALL issue no grants.
REQ-011 PENDING with en=1: at the cycle where cnt==cur_div-1, the next cycle SHALL have cur_div=pend_div, cnt=0, applied=1, and state IDLE.
REQ-012 PENDING with en=0: the change SHALL apply on the next cycle.
REQ-013 A request captured in the same cycle as a period boundary SHALL apply at the following boundary, never the current one.
REQ-014 A captured divisor below 2 SHALL be clamped to 2.
REQ-015 en=0 SHALL hold cnt=0, clk_out=0 and tick=0; the next period SHALL start from cnt=0 when en returns to 1.
REQ-016 At most one grant per cycle; grant SHALL be 0 for requesters with req=0.

Reset
REQ-017 On rst_n=0 the block SHALL set the following immediately, regardless of clock: cnt=0, cur_div=DEFAULT_DIV, clk_out=0, tick=0, grant=0, busy=0, applied=0, state IDLE, rr pointer=0, and discard any pending divisor.
REQ-018 A reset during PENDING SHALL drop the change without a grant retry; the requester re-requests.
REQ-019 The first count SHALL occur on the first rising clk_in after rst_n deasserts.

Structure
REQ-020 A shared package clk_div_pkg SHALL hold the FSM state encoding (IDLE, PENDING) and the constant DIV_MIN=2.
REQ-021 The arbitration SHALL be one sub-module, rr_arbiter (parameter N_REQ; inputs req and advance; output one-hot gnt).
REQ-022 Target size SHALL be 120-400 lines of RTL.

Verification (clk_in 20 ns)
REQ-023 Release reset, en=1, no req -> clk_out period 12 cycles (6 low, 6 high); tick every 12th cycle; cur_div=12.
REQ-024 At cnt=3, req[0]=1 with div=4 -> grant[0] pulses once and busy=1; the 12-cycle period completes, then applied pulses with cur_div=4 and 4-cycle periods (2/2) follow.
REQ-025 req[0]=6 and req[1]=8 raised together -> grant[0], apply 6 at the boundary, then grant[1], apply 8 at the next boundary; a repeated simultaneous request grants requester 1 first.
REQ-026 req_div=0, then 1 -> cur_div=2 both times; clk_out alternates every cycle and tick fires every 2 cycles.
REQ-027 en=0 while PENDING with div=7 -> cur_div=7 next cycle, clk_out=0, tick=0; after en=1, 3 low and 4 high cycles.
REQ-028 rst_n pulsed low while PENDING -> all outputs at their reset values asynchronously, cur_div=12, busy=0, and no applied pulse.
